spi_frame_engine: RTL and testbench
===================================

SPI_FRAME_ENGINE -- requirements
Module: spi_frame_engine

Interface
REQ-001 SHALL have no parameters; widths are fixed: 8-bit command, 32-bit data word, 6-bit bit counter.
REQ-002 clk  input  1  single system clock; all logic is on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 sck  input  1  SPI clock, already synchronized to clk (mode 0).
REQ-005 sdi  input  1  SPI data from host, already synchronized; MSB first.
REQ-006 cs  input  1  SPI chip select, already synchronized, active-low.
REQ-007 sdo  output  1  SPI data to host, driven on every cycle (no tristate).
REQ-008 cmd  output  8  last captured command byte.
REQ-009 cmd_valid  output  1  one-cycle strobe: cmd newly captured.
REQ-010 wr_addr  output  7  cmd[6:0] of the current write frame.
REQ-011 wr_data  output  32  captured write word.
REQ-012 wr_valid  output  1  one-cycle strobe: wr_addr/wr_data valid.
REQ-013 rd_req  output  1  one-cycle strobe: read of address cmd[6:0] requested.
REQ-014 rd_data  input  32  read word; valid exactly 1 clk after rd_req.

Function
REQ-015 sck rising/falling edges SHALL be detected from a 1-cycle delayed copy of sck; edges SHALL be acted on only in cycles where cs=0.
REQ-016 FSM states SHALL be IDLE, CMD, WRITE, READ_LOAD, READ, DONE.
REQ-017 IDLE -> CMD when cs=0; bit counter cleared to 0 on entry.
REQ-018 In CMD, each rising edge shifts sdi into the LSB of an 8-bit shift register and increments the counter.
REQ-019 On the 8th rising edge: cmd updated, cmd_valid=1 on the following cycle; cmd[7]=0 -> WRITE, cmd[7]=1 -> READ_LOAD with rd_req=1 on the same cycle as cmd_valid.
REQ-020 WRITE: 32 further rising edges shift sdi into a 32-bit register, MSB first; on the 40th edge wr_data/wr_addr update and wr_valid=1 on the following cycle; then DONE.
REQ-021 READ_LOAD: on the cycle after rd_req, rd_data is loaded into a 32-bit output shift register; then READ.
REQ-022 READ: sdo SHALL equal shift-register MSB; each falling edge shifts left by one (zero fill); 32 rising edges counted, then DONE.
REQ-023 DONE: further sck edges ignored, sdo=0, until cs=1, then IDLE.
REQ-024 sdo SHALL be 0 in every state other than READ.
REQ-025 cs=1 in any state SHALL return the FSM to IDLE next cycle; an incomplete frame produces no wr_valid; a partial command produces no cmd_valid/rd_req.
REQ-026 cs rising coinciding with the 8th or 40th sck rising edge: the edge SHALL be ignored (cs priority).
REQ-027 Host constraint: sck high and low each at least 4 clk; block behaviour outside this is undefined.
REQ-028 Strobes cmd_valid, wr_valid, rd_req SHALL never be high for two consecutive cycles.

Reset
REQ-029 While rst_n=0: FSM=IDLE, counter=0, all shift registers=0, cmd=0, wr_addr=0, wr_data=0, sdo=0, all strobes=0.
REQ-030 rst_n deassertion mid-frame SHALL leave the block in IDLE; it SHALL not start a frame until cs is seen high then low.

Verification
REQ-031 Write: cs low, shift 0x05 then 0xDEADBEEF, cs high -> cmd_valid once with cmd=0x05; wr_valid once with wr_addr=0x05, wr_data=0xDEADBEEF.
REQ-032 Read: shift 0x83, rd_data=0x12345678 returned 1 clk after rd_req -> rd_req once; sdo bits over next 32 sck periods = 0x12345678 MSB first.
REQ-033 Abort: shift 0x01 plus 20 data bits, raise cs -> cmd_valid once, no wr_valid; next full write frame 0x02/0x00000001 -> wr_valid with wr_data=0x00000001.
REQ-034 Overrun: write frame with 48 sck edges -> exactly one wr_valid, data = first 32 data bits; sdo stays 0.
REQ-035 Reset: assert rst_n=0 after 20 bits of a write frame -> all outputs 0; following complete frame decoded correctly only after cs high/low cycle.
REQ-036 Idle noise: toggle sck 16 times with cs=1 -> no strobes, sdo=0.

Source files
------------

// File: rtl/spi_frame_engine.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_engine
//  Purpose  : SPI mode-0 slave frame decoder. Captures an 8-bit command, then
//             either a 32-bit write word (cmd[7]=0) or serves a 32-bit read
//             word fetched from the system side (cmd[7]=1).
//  Revision : 1.0  initial release
// ============================================================================
module spi_frame_engine (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sck,
   input  logic        sdi,
   input  logic        cs,
   output logic        sdo,
   output logic [7:0]  cmd,
   output logic        cmd_valid,
   output logic [6:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        wr_valid,
   output logic        rd_req,
   input  logic [31:0] rd_data
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CMD       = 3'd1,
      WRITE     = 3'd2,
      READ_LOAD = 3'd3,
      READ      = 3'd4,
      DONE      = 3'd5
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        sck_d;
   logic        armed;
   logic [5:0]  bit_cnt;
   logic [7:0]  cmd_sh;
   logic [31:0] wr_sh;
   logic [31:0] rd_sh;
   logic        sck_rise;
   logic        sck_fall;
   logic        last_cmd_bit;
   logic        last_data_bit;

   // Edges only count while selected; a cs rise on the same cycle wins.
   assign sck_rise      = sck & ~sck_d & ~cs;
   assign sck_fall      = ~sck & sck_d & ~cs;
   assign last_cmd_bit  = sck_rise && (bit_cnt == 6'd7);
   assign last_data_bit = sck_rise && (bit_cnt == 6'd39);

   // Only the read data phase drives the line; every other state holds it low.
   assign sdo = (state == READ) ? rd_sh[31] : 1'b0;

   // Delayed sck copy for edge detection, and the arm flag that requires
   // cs to be seen high after reset before a frame may start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_d <= 1'b0;
         armed <= 1'b0;
      end else begin
         sck_d <= sck;
         if (cs) armed <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; deselect returns to IDLE from anywhere.
   always_comb begin
      state_nxt = state;
      if (cs) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:      if (armed) state_nxt = CMD;
            CMD:       if (last_cmd_bit) state_nxt = cmd_sh[6] ? READ_LOAD : WRITE;
            WRITE:     if (last_data_bit) state_nxt = DONE;
            // rd_req is high on the first READ_LOAD cycle; rd_data arrives on the next.
            READ_LOAD: if (!rd_req) state_nxt = READ;
            READ:      if (last_data_bit) state_nxt = DONE;
            DONE:      state_nxt = DONE;
            default:   state_nxt = IDLE;
         endcase
      end
   end

   // Shift registers, bit counter, captured outputs and one-cycle strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= 6'd0;
         cmd_sh    <= 8'd0;
         wr_sh     <= 32'd0;
         rd_sh     <= 32'd0;
         cmd       <= 8'd0;
         wr_addr   <= 7'd0;
         wr_data   <= 32'd0;
         cmd_valid <= 1'b0;
         wr_valid  <= 1'b0;
         rd_req    <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         wr_valid  <= 1'b0;
         rd_req    <= 1'b0;
         case (state)
            IDLE: begin
               bit_cnt <= 6'd0;
            end
            CMD: begin
               if (sck_rise) begin
                  cmd_sh  <= {cmd_sh[6:0], sdi};
                  bit_cnt <= bit_cnt + 6'd1;
                  if (bit_cnt == 6'd7) begin
                     cmd       <= {cmd_sh[6:0], sdi};
                     cmd_valid <= 1'b1;
                     rd_req    <= cmd_sh[6];
                  end
               end
            end
            WRITE: begin
               if (sck_rise) begin
                  wr_sh   <= {wr_sh[30:0], sdi};
                  bit_cnt <= bit_cnt + 6'd1;
                  if (bit_cnt == 6'd39) begin
                     wr_data  <= {wr_sh[30:0], sdi};
                     wr_addr  <= cmd[6:0];
                     wr_valid <= 1'b1;
                  end
               end
            end
            READ_LOAD: begin
               if (!rd_req) rd_sh <= rd_data;
            end
            READ: begin
               if (sck_rise) bit_cnt <= bit_cnt + 6'd1;
               // The falling edge that follows the last command bit must not
               // shift, otherwise the MSB would never be presented to the host.
               if (sck_fall && (bit_cnt != 6'd8)) rd_sh <= {rd_sh[30:0], 1'b0};
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_frame_engine
//  Purpose  : Self-checking bench for spi_frame_engine. A host model drives
//             SPI frames; expected strobes/values come from frame-level rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_frame_engine;

   localparam int HALF = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sck = 1'b0;
   logic        sdi = 1'b0;
   logic        cs = 1'b1;
   logic        sdo;
   logic [7:0]  cmd;
   logic        cmd_valid;
   logic [6:0]  wr_addr;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic        rd_req;
   logic [31:0] rd_data = 32'd0;

   int          n_vec = 0;
   int          n_err = 0;

   // observation state kept by the monitor
   int          tot_cmdv = 0;
   int          tot_wrv = 0;
   int          tot_rd = 0;
   int          consec_err = 0;
   int          misalign_err = 0;
   logic [7:0]  last_cmd = 8'd0;
   logic [6:0]  last_wa = 7'd0;
   logic [31:0] last_wd = 32'd0;
   logic        p_c = 1'b0, p_w = 1'b0, p_r = 1'b0;
   logic        rd_seen = 1'b0;
   logic [31:0] rd_value = 32'd0;

   spi_frame_engine dut (
      .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .cs(cs), .sdo(sdo),
      .cmd(cmd), .cmd_valid(cmd_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_valid(wr_valid), .rd_req(rd_req), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   // Strobe monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (cmd_valid) begin tot_cmdv++; last_cmd = cmd; end
      if (wr_valid)  begin tot_wrv++; last_wa = wr_addr; last_wd = wr_data; end
      if (rd_req) begin
         tot_rd++;
         if (!cmd_valid || !cmd[7]) misalign_err++;
      end
      if ((cmd_valid && p_c) || (wr_valid && p_w) || (rd_req && p_r)) consec_err++;
      p_c = cmd_valid;
      p_w = wr_valid;
      p_r = rd_req;
      rd_seen = rd_req;
   end

   // System-side read port: the word is present only in the cycle after rd_req.
   always @(posedge clk) begin
      #1;
      rd_data = rd_seen ? rd_value : ~rd_value;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Host: shifts n bits of the stream MSB first; optionally raises cs together
   // with the last rising edge. Returns sdo sampled at rising edges 9..40.
   task automatic shift_bits(input logic [47:0] s, input int n, input bit cs_last,
                             output logic [31:0] so);
      so = 32'd0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sdi = s[47-i];
         repeat (HALF) @(negedge clk);
         if (i >= 8 && i < 40) so = {so[30:0], sdo};
         sck = 1'b1;
         if (cs_last && i == n - 1) cs = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   // One complete frame plus frame-level reference checks.
   task automatic run_frame(input string tag, input logic [7:0] c, input logic [31:0] d,
                            input int n, input bit cs_last);
      logic [31:0] so;
      logic [7:0]  extra;
      int s_c, s_w, s_r, eff;
      bit exp_cmdv, exp_rd, exp_wr;
      extra = 8'($urandom);
      s_c = tot_cmdv; s_w = tot_wrv; s_r = tot_rd;
      cs = 1'b0;
      repeat (3) @(negedge clk);
      shift_bits({c, d, extra}, n, cs_last, so);
      repeat (3) @(negedge clk);
      cs = 1'b1;
      repeat (6) @(negedge clk);
      eff      = cs_last ? n - 1 : n;
      exp_cmdv = (eff >= 8);
      exp_rd   = (eff >= 8) && c[7];
      exp_wr   = (eff >= 40) && !c[7];
      chk({tag, ".cmd_valid_cnt"}, 64'(tot_cmdv - s_c), 64'(exp_cmdv));
      if (exp_cmdv) chk({tag, ".cmd"}, 64'(last_cmd), 64'(c));
      chk({tag, ".rd_req_cnt"}, 64'(tot_rd - s_r), 64'(exp_rd));
      chk({tag, ".wr_valid_cnt"}, 64'(tot_wrv - s_w), 64'(exp_wr));
      if (exp_wr) begin
         chk({tag, ".wr_addr"}, 64'(last_wa), 64'(c[6:0]));
         chk({tag, ".wr_data"}, 64'(last_wd), 64'(d));
      end
      if (!c[7])       chk({tag, ".sdo_idle"}, 64'(so), 64'd0);
      else if (n >= 40) chk({tag, ".sdo_read"}, 64'(so), 64'(rd_value));
   endtask

   // Directed sequence followed by randomized frames.
   initial begin
      logic [31:0] so;
      int s_c, s_w, s_r;
      logic        sdo_seen;

      repeat (3) @(negedge clk);
      chk("reset.outputs", {sdo, cmd, cmd_valid, wr_addr, wr_data, wr_valid, rd_req}, 64'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      run_frame("write", 8'h05, 32'hDEADBEEF, 40, 1'b0);
      rd_value = 32'h12345678;
      run_frame("read", 8'h83, 32'h0, 40, 1'b0);
      run_frame("abort", 8'h01, 32'hA5A5A5A5, 28, 1'b0);
      run_frame("after_abort", 8'h02, 32'h00000001, 40, 1'b0);
      run_frame("overrun", 8'h11, 32'hCAFEF00D, 48, 1'b0);
      run_frame("cs_on_8th", 8'h07, 32'h0, 8, 1'b1);
      run_frame("cs_on_40th", 8'h09, 32'h13572468, 40, 1'b1);
      run_frame("partial_cmd", 8'h85, 32'h0, 5, 1'b0);

      // Reset mid-frame, then a frame without a cs high/low cycle is ignored.
      cs = 1'b0;
      repeat (3) @(negedge clk);
      shift_bits({8'h04, 32'h89ABCDEF, 8'h00}, 20, 1'b0, so);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mid.outputs", {sdo, cmd, cmd_valid, wr_addr, wr_data, wr_valid, rd_req}, 64'd0);
      s_c = tot_cmdv; s_w = tot_wrv; s_r = tot_rd;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      shift_bits({8'h04, 32'h89ABCDEF, 8'h00}, 40, 1'b0, so);
      repeat (3) @(negedge clk);
      chk("rst_mid.no_start", 64'((tot_cmdv - s_c) + (tot_wrv - s_w) + (tot_rd - s_r)), 64'd0);
      cs = 1'b1;
      repeat (6) @(negedge clk);
      run_frame("after_reset", 8'h04, 32'h89ABCDEF, 40, 1'b0);

      // sck toggling while deselected.
      s_c = tot_cmdv; s_w = tot_wrv; s_r = tot_rd;
      sdo_seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sdi = 1'($urandom);
         sck = 1'b1;
         repeat (HALF) @(negedge clk);
         sdo_seen = sdo_seen | sdo;
         sck = 1'b0;
         repeat (HALF) @(negedge clk);
         sdo_seen = sdo_seen | sdo;
      end
      chk("idle_noise.strobes", 64'((tot_cmdv - s_c) + (tot_wrv - s_w) + (tot_rd - s_r)), 64'd0);
      chk("idle_noise.sdo", 64'(sdo_seen), 64'd0);

      // Randomized frames: random command, data, length and cs-race choice.
      for (int k = 0; k < 10; k++) begin
         logic [7:0]  rc;
         logic [31:0] rdw;
         int          len;
         bit          race;
         rc   = 8'($urandom);
         rdw  = $urandom;
         rd_value = $urandom;
         len  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 48)) : 40;
         race = ($urandom_range(0, 3) == 0);
         run_frame("random", rc, rdw, len, race);
      end

      chk("strobe_consecutive", 64'(consec_err), 64'd0);
      chk("rd_req_alignment", 64'(misalign_err), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
